ifu_fetch: RTL and testbench

Instruction fetch stage that sits directly upstream of the instruction decode stage and supplies its 32-bit `inst`.
- Owns the PC register and issues one word-aligned fetch at a time to instruction memory over a valid/ready request and valid-only response interface.
- Buffers returned words in a small FIFO.
- Presents words to decode with a valid/ready handshake.
- Accepts redirects (branch/jump/trap target) from execute and discards stale fetches.

---
 rtl/ifu_fetch.sv | 162 ++++++++++++++++
 tb/tb_ifu_fetch.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch.sv
// Instruction fetch stage: owns the PC, issues one fetch at a time and buffers words for decode.
// Optional misaligned-redirect trap (sticky flag + HALT) enabled by defining IFU_MISALIGN_CHK_EN.
module ifu_fetch #(
    parameter int unsigned     XLEN       = 64,
    parameter logic [XLEN-1:0] RESET_PC   = XLEN'(64'h8000_0000),
    parameter int unsigned     FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [31:0]     imem_resp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] inst_pc,
    output logic            fetch_misalign
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

`ifdef IFU_MISALIGN_CHK_EN
    typedef enum logic [2:0] {IDLE, REQ, WAIT, DROP, HALT} state_e;
`else
    typedef enum logic [2:0] {IDLE, REQ, WAIT, DROP} state_e;
`endif

    state_e            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   req_pc_q, req_pc_d;
    logic [PTR_W-1:0]  head_q, tail_q;
    logic [CNT_W-1:0]  count_q;
    logic [31:0]       buf_data [FIFO_DEPTH];
    logic [XLEN-1:0]   buf_pc   [FIFO_DEPTH];
    logic              push, pop, flush, req_fire, redirect_live;
    logic [XLEN-1:0]   redirect_tgt;

    assign imem_req_valid = (state_q == REQ) && (count_q < CNT_W'(FIFO_DEPTH));
    assign imem_req_addr  = pc_q;
    assign inst_valid     = (count_q != '0);
    assign inst           = buf_data[head_q];
    assign inst_pc        = buf_pc[head_q];
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign pop            = inst_valid && inst_ready && !flush;
    assign redirect_tgt   = {redirect_pc[XLEN-1:2], 2'b00};

`ifdef IFU_MISALIGN_CHK_EN
    logic misalign_q, misalign_d;
    assign redirect_live  = redirect_valid && (state_q != HALT);
    assign fetch_misalign = misalign_q;
`else
    logic unused_low_bits;
    assign unused_low_bits = ^redirect_pc[1:0];
    assign redirect_live   = redirect_valid;
    assign fetch_misalign  = 1'b0;
`endif

    // State, PC and flag registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            req_pc_q <= '0;
`ifdef IFU_MISALIGN_CHK_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
`ifdef IFU_MISALIGN_CHK_EN
            misalign_q <= misalign_d;
`endif
        end
    end

    // Next state; a redirect overrides everything else in its cycle
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        push     = 1'b0;
        flush    = 1'b0;
`ifdef IFU_MISALIGN_CHK_EN
        misalign_d = misalign_q;
`endif
        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (req_fire) begin
                    req_pc_d = pc_q;
                    pc_d     = pc_q + XLEN'(4);
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (imem_resp_valid) begin
                    push    = 1'b1;
                    state_d = REQ;
                end
            end
            DROP: begin
                if (imem_resp_valid) begin
                    state_d = REQ;
                end
            end
            default: ;
        endcase

        if (redirect_live) begin
            flush = 1'b1;
            push  = 1'b0;
            pc_d  = redirect_tgt;
            case (state_q)
                REQ:     state_d = req_fire ? DROP : REQ;
                WAIT:    state_d = imem_resp_valid ? REQ : DROP;
                DROP:    state_d = DROP;
                default: state_d = REQ;
            endcase
`ifdef IFU_MISALIGN_CHK_EN
            if (redirect_pc[1:0] != 2'b00) begin
                state_d    = HALT;
                misalign_d = 1'b1;
                pc_d       = pc_q;
            end
`endif
        end
    end

    // Instruction buffer: circular FIFO of {pc, word}
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                buf_data[i] <= '0;
                buf_pc[i]   <= '0;
            end
        end else if (flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                buf_data[tail_q] <= imem_resp_data;
                buf_pc[tail_q]   <= req_pc_q;
                tail_q           <= tail_q + PTR_W'(1);
            end
            if (pop) begin
                head_q <= head_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed self-checking bench for ifu_fetch: fetch, backpressure, redirects, async reset, misalign.
module tb_ifu_fetch;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic        fetch_misalign;

    int total = 0;
    int bad   = 0;

    ifu_fetch dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst            (inst),
        .inst_pc         (inst_pc),
        .fetch_misalign  (fetch_misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Outputs are sampled and inputs driven just after the falling edge
    task automatic step();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        redirect_valid  = 1'b0;
        redirect_pc     = '0;
        inst_ready      = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        clear_inputs();
        step();
        rst = 1'b1;
        step();
    endtask

    // Accept the pending request, then answer it in the following cycle
    task automatic fetch_one(input logic [31:0] d);
        imem_req_ready = 1'b1;
        step();
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b1;
        imem_resp_data  = d;
        step();
        imem_resp_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        clear_inputs();
        step();
        step();
        total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL rst_req_valid got=%0h exp=0", imem_req_valid); end
        total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL rst_inst_valid got=%0h exp=0", inst_valid); end
        total++; if (inst !== 32'h0) begin bad++; $display("FAIL rst_inst got=%0h exp=0", inst); end
        total++; if (inst_pc !== 64'h0) begin bad++; $display("FAIL rst_inst_pc got=%0h exp=0", inst_pc); end
        total++; if (fetch_misalign !== 1'b0) begin bad++; $display("FAIL rst_misalign got=%0h exp=0", fetch_misalign); end
        rst = 1'b1;
        step();
        total++; if (imem_req_valid !== 1'b1) begin bad++; $display("FAIL rst_first_req got=%0h exp=1", imem_req_valid); end
        total++; if (imem_req_addr !== 64'h8000_0000) begin bad++; $display("FAIL rst_first_addr got=%0h exp=80000000", imem_req_addr); end
    endtask

    task automatic test_basic();
        inst_ready     = 1'b1;
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL basic_wait_novalid got=%0h exp=0", imem_req_valid); end
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'h0000_0013;
        step();
        imem_resp_valid = 1'b0;
        total++; if (inst_valid !== 1'b1) begin bad++; $display("FAIL basic_v0 got=%0h exp=1", inst_valid); end
        total++; if (inst !== 32'h0000_0013) begin bad++; $display("FAIL basic_inst0 got=%0h exp=13", inst); end
        total++; if (inst_pc !== 64'h8000_0000) begin bad++; $display("FAIL basic_pc0 got=%0h exp=80000000", inst_pc); end
        total++; if (imem_req_addr !== 64'h8000_0004) begin bad++; $display("FAIL basic_addr1 got=%0h exp=80000004", imem_req_addr); end
        total++; if (imem_req_valid !== 1'b1) begin bad++; $display("FAIL basic_req1 got=%0h exp=1", imem_req_valid); end
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL basic_popped got=%0h exp=0", inst_valid); end
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'h0010_0073;
        step();
        imem_resp_valid = 1'b0;
        inst_ready      = 1'b0;
        total++; if (inst !== 32'h0010_0073) begin bad++; $display("FAIL basic_inst1 got=%0h exp=100073", inst); end
        total++; if (inst_pc !== 64'h8000_0004) begin bad++; $display("FAIL basic_pc1 got=%0h exp=80000004", inst_pc); end
    endtask

    task automatic test_backpressure();
        do_reset();
        fetch_one(32'h0000_00aa);
        total++; if (imem_req_addr !== 64'h8000_0004) begin bad++; $display("FAIL bp_addr1 got=%0h exp=80000004", imem_req_addr); end
        fetch_one(32'h0000_00bb);
        total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL bp_full_stall got=%0h exp=0", imem_req_valid); end
        total++; if (imem_req_addr !== 64'h8000_0008) begin bad++; $display("FAIL bp_full_pc got=%0h exp=80000008", imem_req_addr); end
        imem_req_ready = 1'b1;
        step();
        total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL bp_still_stall got=%0h exp=0", imem_req_valid); end
        total++; if (inst !== 32'h0000_00aa) begin bad++; $display("FAIL bp_head0 got=%0h exp=aa", inst); end
        inst_ready = 1'b1;
        step();
        total++; if (inst !== 32'h0000_00bb) begin bad++; $display("FAIL bp_head1 got=%0h exp=bb", inst); end
        total++; if (inst_pc !== 64'h8000_0004) begin bad++; $display("FAIL bp_head1_pc got=%0h exp=80000004", inst_pc); end
        total++; if (imem_req_valid !== 1'b1) begin bad++; $display("FAIL bp_resume got=%0h exp=1", imem_req_valid); end
        total++; if (imem_req_addr !== 64'h8000_0008) begin bad++; $display("FAIL bp_resume_addr got=%0h exp=80000008", imem_req_addr); end
        step();
        imem_req_ready = 1'b0;
        total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL bp_drained got=%0h exp=0", inst_valid); end
    endtask

    task automatic test_redirect_wait();
        do_reset();
        inst_ready     = 1'b1;
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0100;
        step();
        redirect_valid = 1'b0;
        total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL rw_drop_noreq got=%0h exp=0", imem_req_valid); end
        total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL rw_empty got=%0h exp=0", inst_valid); end
        step();
        step();
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'hdead_beef;
        step();
        imem_resp_valid = 1'b0;
        total++; if (imem_req_valid !== 1'b1) begin bad++; $display("FAIL rw_req got=%0h exp=1", imem_req_valid); end
        total++; if (imem_req_addr !== 64'h8000_0100) begin bad++; $display("FAIL rw_addr got=%0h exp=80000100", imem_req_addr); end
        step();
        total++; if (inst_valid !== 1'b0 || inst === 32'hdead_beef) begin bad++; $display("FAIL rw_stale got=%0h/%0h exp=0/not-deadbeef", inst_valid, inst); end
    endtask

    task automatic test_redirect_resp();
        do_reset();
        fetch_one(32'h0000_0011);
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        total++; if (inst_valid !== 1'b1) begin bad++; $display("FAIL rr_held got=%0h exp=1", inst_valid); end
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'h0000_0022;
        redirect_valid  = 1'b1;
        redirect_pc     = 64'h8000_0200;
        step();
        imem_resp_valid = 1'b0;
        redirect_valid  = 1'b0;
        total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL rr_flushed got=%0h exp=0", inst_valid); end
        total++; if (imem_req_addr !== 64'h8000_0200) begin bad++; $display("FAIL rr_addr got=%0h exp=80000200", imem_req_addr); end
        fetch_one(32'h0000_0033);
        total++; if (inst !== 32'h0000_0033) begin bad++; $display("FAIL rr_newinst got=%0h exp=33", inst); end
        total++; if (inst_pc !== 64'h8000_0200) begin bad++; $display("FAIL rr_newpc got=%0h exp=80000200", inst_pc); end
        // redirect on the same edge as a request handshake
        imem_req_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0300;
        step();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b0;
        total++; if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin bad++; $display("FAIL rr_hs_drop got=%0h/%0h exp=0/0", imem_req_valid, inst_valid); end
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'h0000_0044;
        step();
        imem_resp_valid = 1'b0;
        total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL rr_hs_discard got=%0h exp=0", inst_valid); end
        total++; if (imem_req_addr !== 64'h8000_0300) begin bad++; $display("FAIL rr_hs_addr got=%0h exp=80000300", imem_req_addr); end
    endtask

    task automatic test_pc_wrap();
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc    = 64'hffff_ffff_ffff_fffc;
        step();
        redirect_valid = 1'b0;
        total++; if (imem_req_addr !== 64'hffff_ffff_ffff_fffc) begin bad++; $display("FAIL wrap_addr got=%0h exp=fffffffffffffffc", imem_req_addr); end
        fetch_one(32'h0000_0077);
        total++; if (inst_pc !== 64'hffff_ffff_ffff_fffc) begin bad++; $display("FAIL wrap_instpc got=%0h exp=fffffffffffffffc", inst_pc); end
        total++; if (imem_req_addr !== 64'h0) begin bad++; $display("FAIL wrap_next got=%0h exp=0", imem_req_addr); end
    endtask

    task automatic test_async_reset();
        do_reset();
        fetch_one(32'h0000_0055);
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        #2 rst = 1'b0;
        #1;
        total++; if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin bad++; $display("FAIL ar_outputs got=%0h/%0h exp=0/0", imem_req_valid, inst_valid); end
        total++; if (inst !== 32'h0 || inst_pc !== 64'h0) begin bad++; $display("FAIL ar_inst got=%0h/%0h exp=0/0", inst, inst_pc); end
        step();
        rst             = 1'b1;
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'h0000_0066;
        step();
        total++; if (imem_req_valid !== 1'b1) begin bad++; $display("FAIL ar_req got=%0h exp=1", imem_req_valid); end
        total++; if (imem_req_addr !== 64'h8000_0000) begin bad++; $display("FAIL ar_addr got=%0h exp=80000000", imem_req_addr); end
        step();
        imem_resp_valid = 1'b0;
        total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL ar_stale got=%0h exp=0", inst_valid); end
    endtask

    task automatic test_misalign();
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0102;
        step();
        redirect_valid = 1'b0;
`ifdef IFU_MISALIGN_CHK_EN
        begin
            int reqs;
            reqs = 0;
            total++; if (fetch_misalign !== 1'b1) begin bad++; $display("FAIL mis_flag got=%0h exp=1", fetch_misalign); end
            imem_req_ready = 1'b1;
            for (int i = 0; i < 20; i++) begin
                if (imem_req_valid === 1'b1 || inst_valid === 1'b1) reqs++;
                step();
            end
            imem_req_ready = 1'b0;
            total++; if (reqs !== 0) begin bad++; $display("FAIL mis_halt_activity got=%0d exp=0", reqs); end
            total++; if (fetch_misalign !== 1'b1) begin bad++; $display("FAIL mis_sticky got=%0h exp=1", fetch_misalign); end
            do_reset();
            total++; if (fetch_misalign !== 1'b0 || imem_req_valid !== 1'b1) begin bad++; $display("FAIL mis_reset_clear got=%0h/%0h exp=0/1", fetch_misalign, imem_req_valid); end
        end
`else
        total++; if (fetch_misalign !== 1'b0) begin bad++; $display("FAIL mis_flag got=%0h exp=0", fetch_misalign); end
        total++; if (imem_req_valid !== 1'b1) begin bad++; $display("FAIL mis_req got=%0h exp=1", imem_req_valid); end
        total++; if (imem_req_addr !== 64'h8000_0100) begin bad++; $display("FAIL mis_addr got=%0h exp=80000100", imem_req_addr); end
`endif
    endtask

    initial begin
        rst = 1'b0;
        clear_inputs();
        test_reset();
        test_basic();
        test_backpressure();
        test_redirect_wait();
        test_redirect_resp();
        test_pc_wrap();
        test_async_reset();
        test_misalign();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
